// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo issue path: RS index map, opcodes, class decode.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package tomasulo_pkg;

    localparam int RS_IW = 4;

    localparam logic [RS_IW-1:0] RS_ADD1  = 4'd7;
    localparam logic [RS_IW-1:0] RS_ADD2  = 4'd8;
    localparam logic [RS_IW-1:0] RS_ADD3  = 4'd9;
    localparam logic [RS_IW-1:0] RS_MULT1 = 4'd10;
    localparam logic [RS_IW-1:0] RS_MULT2 = 4'd11;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        CLS_LS,
        CLS_ADD,
        CLS_MULT,
        CLS_ILLEGAL
    } instr_class_e;

    typedef enum logic {
        ST_RUN,
        ST_STALL
    } disp_state_e;

    // Map opcode/funct7 onto the reservation-station class that executes it
    function automatic instr_class_e decode_class(input logic [6:0] opcode,
                                                  input logic [6:0] funct7);
        instr_class_e cls;
        cls = CLS_ILLEGAL;
        if (opcode == OP_LOAD || opcode == OP_STORE) begin
            cls = CLS_LS;
        end else if (opcode == OP_REG && funct7 == F7_MULDIV) begin
            cls = CLS_MULT;
        end else if (opcode == OP_REG || opcode == OP_IMM) begin
            cls = CLS_ADD;
        end
        return cls;
    endfunction

endpackage

// File: rtl/rs_pick.sv
// Lowest-set-bit finder over a candidate mask of free reservation stations.
// Latency: combinational.
// Backpressure: none; found=0 tells the caller the class is full.
module rs_pick #(
    parameter int W  = 4,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  cand,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Scan from the top so the lowest set bit is the last one to win
    always_comb begin
        found = |cand;
        idx   = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (cand[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/dispatch_alloc.sv
// In-order issue allocator: assigns ROB tail entry plus lowest free RS of the decoded class.
// Latency: accept in cycle N -> issue_valid / index_* registered in cycle N+1, one cycle wide.
// Backpressure: in_ready drops on ROB-tail busy or class full; optional DISPATCH_STALL_CNT_EN adds stall_cnt.
module dispatch_alloc
    import tomasulo_pkg::*;
#(
    parameter int ROB_DEPTH = 8,
    parameter int LS_N      = 4,
    localparam int TW       = $clog2(ROB_DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [31:0]         in_instr,
    output logic                in_ready,
    input  logic [ROB_DEPTH-1:0] rob_busy,
    input  logic [LS_N-1:0]     ls_busy,
    input  logic [2:0]          add_busy,
    input  logic [1:0]          mult_busy,
    output logic                issue_valid,
    output logic [TW-1:0]       index_rb,
    output logic [RS_IW-1:0]    index_rs,
    output logic [31:0]         instruction,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic                illegal
`ifdef DISPATCH_STALL_CNT_EN
    ,
    output logic [15:0]         stall_cnt
`endif
);

    localparam int LS_IW = (LS_N > 1) ? $clog2(LS_N) : 1;

    instr_class_e       cls;
    logic               ls_found, add_found, mult_found;
    logic [LS_IW-1:0]   ls_idx;
    logic [1:0]         add_idx;
    logic               mult_idx;
    logic               slot_avail;
    logic [RS_IW-1:0]   pick_rs;
    logic               rob_free;
    logic               accept;
    logic               legal_acc;
    logic               illegal_acc;

    logic [TW-1:0]      tail_q, tail_d;
    logic [LS_N-1:0]    res_ls_q, res_ls_d;
    logic [2:0]         res_add_q, res_add_d;
    logic [1:0]         res_mult_q, res_mult_d;
    logic               issue_valid_q, issue_valid_d;
    logic               illegal_q, illegal_d;
    logic [TW-1:0]      index_rb_q, index_rb_d;
    logic [RS_IW-1:0]   index_rs_q, index_rs_d;
    logic [31:0]        instruction_q, instruction_d;
    logic [4:0]         rs1_q, rs1_d;
    logic [4:0]         rs2_q, rs2_d;
    disp_state_e        state_q, state_d;

    assign cls = decode_class(in_instr[6:0], in_instr[31:25]);

    // Reserved slots hide the one-cycle lag before the RS raises its own busy flag
    rs_pick #(.W(LS_N), .IW(LS_IW)) u_pick_ls (
        .cand  (~ls_busy & ~res_ls_q),
        .found (ls_found),
        .idx   (ls_idx)
    );

    rs_pick #(.W(3), .IW(2)) u_pick_add (
        .cand  (~add_busy & ~res_add_q),
        .found (add_found),
        .idx   (add_idx)
    );

    rs_pick #(.W(2), .IW(1)) u_pick_mult (
        .cand  (~mult_busy & ~res_mult_q),
        .found (mult_found),
        .idx   (mult_idx)
    );

    // Select the slot availability and global RS index for the offered class
    always_comb begin
        slot_avail = 1'b0;
        pick_rs    = '0;
        case (cls)
            CLS_LS: begin
                slot_avail = ls_found;
                pick_rs    = RS_IW'(ls_idx);
            end
            CLS_ADD: begin
                slot_avail = add_found;
                pick_rs    = RS_ADD1 + RS_IW'(add_idx);
            end
            CLS_MULT: begin
                slot_avail = mult_found;
                pick_rs    = RS_MULT1 + RS_IW'(mult_idx);
            end
            default: begin
                slot_avail = 1'b0;
                pick_rs    = '0;
            end
        endcase
    end

    // Handshake: the same-cycle commit of the tail entry is deliberately not bypassed
    always_comb begin
        rob_free    = !rob_busy[tail_q];
        in_ready    = !rst_n && ((cls == CLS_ILLEGAL) || (rob_free && slot_avail));
        accept      = in_valid && in_ready;
        illegal_acc = accept && (cls == CLS_ILLEGAL);
        legal_acc   = accept && (cls != CLS_ILLEGAL);
    end

    // Next-state of the allocation datapath; data outputs hold when nothing issues
    always_comb begin
        tail_d        = tail_q;
        res_ls_d      = '0;
        res_add_d     = '0;
        res_mult_d    = '0;
        issue_valid_d = legal_acc;
        illegal_d     = illegal_acc;
        index_rb_d    = index_rb_q;
        index_rs_d    = index_rs_q;
        instruction_d = instruction_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        if (illegal_acc) begin
            res_ls_d   = res_ls_q;
            res_add_d  = res_add_q;
            res_mult_d = res_mult_q;
        end
        if (legal_acc) begin
            tail_d        = tail_q + TW'(1);
            index_rb_d    = tail_q;
            index_rs_d    = pick_rs;
            instruction_d = in_instr;
            rs1_d         = in_instr[19:15];
            rs2_d         = in_instr[24:20];
            case (cls)
                CLS_LS:   res_ls_d   = LS_N'(1) << ls_idx;
                CLS_ADD:  res_add_d  = 3'b001 << add_idx;
                CLS_MULT: res_mult_d = 2'b01 << mult_idx;
                default:  ;
            endcase
        end
    end

    // Datapath registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst_n) begin
            tail_q        <= '0;
            res_ls_q      <= '0;
            res_add_q     <= '0;
            res_mult_q    <= '0;
            issue_valid_q <= 1'b0;
            illegal_q     <= 1'b0;
            index_rb_q    <= '0;
            index_rs_q    <= '0;
            instruction_q <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
        end else begin
            tail_q        <= tail_d;
            res_ls_q      <= res_ls_d;
            res_add_q     <= res_add_d;
            res_mult_q    <= res_mult_d;
            issue_valid_q <= issue_valid_d;
            illegal_q     <= illegal_d;
            index_rb_q    <= index_rb_d;
            index_rs_q    <= index_rs_d;
            instruction_q <= instruction_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
        end
    end

    assign issue_valid = issue_valid_q;
    assign illegal     = illegal_q;
    assign index_rb    = index_rb_q;
    assign index_rs    = index_rs_q;
    assign instruction = instruction_q;
    assign rs1         = rs1_q;
    assign rs2         = rs2_q;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: STALL while the head instruction is refused, back to RUN on accept
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (in_valid && !in_ready) state_d = ST_STALL;
            ST_STALL: if (accept)                state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

`ifdef DISPATCH_STALL_CNT_EN
    logic        stall_inc;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // FSM output: count stalled cycles, saturating
    always_comb begin
        stall_inc   = (state_q == ST_STALL) && (stall_cnt_q != 16'hFFFF);
        stall_cnt_d = stall_inc ? stall_cnt_q + 16'd1 : stall_cnt_q;
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/dispatch_alloc.md
# dispatch_alloc

Issue-side allocator for the Tomasulo core. It accepts decoded-in-order instructions over a valid/ready handshake and assigns each one a reorder-buffer entry (tail pointer) and a free reservation station of the correct class. It then drives the registered allocation (`index_rb`, `index_rs`, `instruction`, `rs1`, `rs2`) into the reorder buffer and the reservation stations. It stalls on structural hazards reported by the ROB `busy*` flags and the per-class RS busy flags.

## Interface
- `ROB_DEPTH`, 8: reorder-buffer entries; must be a power of 2, and the tail pointer is log2 of it.
- `LS_N`, 4: load/store buffers, occupying RS indices 0..LS_N-1 (LS_N ≤ 7).
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, **active-high**. The name is historical; a value of 1 resets the block.
- `in_valid` input 1: an instruction is offered.
- `in_instr` input 32: RV32 instruction word.
- `in_ready` output 1: the instruction is accepted this cycle if `in_valid` is also high.
- `rob_busy` input ROB_DEPTH: busy flag of each ROB entry.
- `ls_busy` input LS_N: load/store buffer busy flags.
- `add_busy` input 3: ADD1..ADD3 busy flags.
- `mult_busy` input 2: MULT1..MULT2 busy flags.
- `issue_valid` output 1: registered; the allocation fields below are valid.
- `index_rb` output 3: allocated ROB entry.
- `index_rs` output 4: allocated RS (LS 0..LS_N-1, ADD 7/8/9, MULT 10/11).
- `instruction` output 32: registered copy of the instruction.
- `rs1`, `rs2` output 5 each: `in_instr[19:15]` and `[24:20]`, registered.
- `illegal` output 1: registered one-cycle pulse when an unsupported opcode is consumed.

## Operation
- Class decode:
  - opcode 0000011 or 0100011 → LS.
  - opcode 0110011 with funct7 0000001 → MULT.
  - opcode 0110011 (other funct7) or 0010011 → ADD.
  - Anything else → ILLEGAL.
- Free-slot pick uses the lowest index first within the class. The candidate mask is `~busy & ~reserved`.
- `reserved` is a register holding the slot picked in the previous accept cycle, asserted for exactly one cycle. It covers the lag before the RS raises its own busy flag.
- `rob_free` = `!rob_busy[tail]`.
- `in_ready` = `!rst_n & rob_free & class_slot_available`. ILLEGAL needs only `!rst_n`. `in_ready` is combinational on `in_instr`.
- On accept of a non-ILLEGAL instruction:
  - Register the outputs and pulse `issue_valid`.
  - Advance `tail` by 1, wrapping from ROB_DEPTH-1 to 0.
  - Load `reserved` with the picked slot.
- On accept of an ILLEGAL instruction: pulse `illegal`. `tail` and `reserved` are unchanged, and `issue_valid` stays 0.
- A cycle with no accept gives `issue_valid` = 0 and `reserved` cleared; the data outputs hold their previous values.
- State machine:
  - RUN: normal operation.
  - STALL: entered when `in_valid & !in_ready`; exits to RUN on the first accept.
  - STALL affects only the optional counter.

## Timing
- Accept in cycle N → `issue_valid`/`index_*` high in cycle N+1 for one cycle. Back-to-back accepts give back-to-back issues.
- Reset values: `tail` = 0, `reserved` = 0, state RUN, `issue_valid` = 0, `illegal` = 0, `index_rb` = 0, `index_rs` = 0, `instruction` = 0, `rs1` = 0, `rs2` = 0, `in_ready` = 0 while reset is asserted.
- Reset mid-stream: an accept in the reset cycle is discarded, and any in-flight `issue_valid` is cleared on the next edge.
- ROB full (`rob_busy[tail]`=1): `in_ready` = 0 until that entry commits. There is no bypass of the same-cycle commit.
- Class full (all slots busy or reserved): `in_ready` = 0. Other classes are not blocked, but order is strictly in order, so the head instruction blocks the whole stream.
- A slot freed and picked in the same cycle is legal.

## Configuration
- `DISPATCH_STALL_CNT_EN` defined: adds output `stall_cnt`, 16 bits. It increments each cycle in STALL, saturates at 0xFFFF, and resets to 0.
- `DISPATCH_STALL_CNT_EN` undefined: the port and counter are absent; the state machine is still present.

## Structure
- Shared package `tomasulo_pkg`:
  - RS index constants: `RS_ADD1`=7, `RS_ADD2`=8, `RS_ADD3`=9, `RS_MULT1`=10, `RS_MULT2`=11.
  - Class enum: LS, ADD, MULT, ILLEGAL.
  - Opcode constants.
- One sub-module, `rs_pick`: parameterized-width lowest-set-bit finder returning `found` and `idx`. It is instantiated once per class.

## Test plan
- Reset, then 3 back-to-back ADDs (0x002081B3) with all idle → `issue_valid` for 3 cycles; `index_rb` 0,1,2; `index_rs` 7,8,9.
- MULT (funct7 0000001) twice while `mult_busy` stays 0 → `index_rs` 10 then 11. The second pick proves `reserved` masking.
- `rob_busy`=0xFF with an ADD offered → `in_ready` = 0 for 5 cycles. Clear bit 0 → accept next cycle with `index_rb` 0.
- Load 0x0000A103 with `ls_busy`=0b0111 → `index_rs` 3, `rs1` 1. With `ls_busy`=0b1111 → stall until a bit clears.
- Opcode 0x7F offered → `illegal` pulses once, `issue_valid` = 0, `tail` unchanged.
- 9 accepts with ROB drained → `index_rb` wraps 7→0. Assert `rst_n` in cycle 4 → `issue_valid` = 0 next cycle and `tail` back to 0.
